dcpu_int_queue: RTL and testbench

Interrupt queue and arbiter that sits directly upstream of the DCPU-16 core. It collects interrupt requests from hardware devices and from the core's own INT instruction, and buffers them in a FIFO of up to DEPTH messages. It presents them to the core one at a time, and only while the core has interrupt queueing disabled. Queue overflow sets the sticky CATCH_FIRE flag, which the top level wires into the core's halt logic.

---
 rtl/dcpu_int_queue.sv | 117 +++++++++++
 tb/tb_dcpu_int_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_int_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dcpu_int_queue
// Description : Interrupt FIFO and fixed-priority arbiter feeding the DCPU-16
//               core; overflow sets the sticky CATCH_FIRE flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dcpu_int_queue #(
    parameter int DEPTH = 256,
    parameter int N_SRC = 4
) (
    input  logic                     CORE_CLK,
    input  logic                     RESET_N,
    input  logic [N_SRC-1:0]         SRC_req,
    input  logic [16*N_SRC-1:0]      SRC_msg,
    output logic [N_SRC-1:0]         SRC_ack,
    input  logic                     SW_req,
    input  logic [15:0]              SW_msg,
    output logic                     SW_ack,
    input  logic                     IAQ,
    input  logic                     IA_zero,
    output logic                     INT_valid,
    output logic [15:0]              INT_msg,
    input  logic                     INT_take,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     CATCH_FIRE
);

    localparam int                c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_full   = (c_addr_w + 1)'(DEPTH);

    logic [15:0]         r_mem [DEPTH];
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_fire;

    logic                w_src_any;
    logic [N_SRC-1:0]    w_src_oh;
    logic [15:0]         w_src_msg;
    logic                w_any;
    logic [15:0]         w_win_msg;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_enq;
    logic                w_ovf;
    logic                w_accept;

    // Scan from the top index down so the lowest requesting source wins.
    always_comb begin
        w_src_any = 1'b0;
        w_src_oh  = '0;
        w_src_msg = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (SRC_req[i]) begin
                w_src_any   = 1'b1;
                w_src_oh    = '0;
                w_src_oh[i] = 1'b1;
                w_src_msg   = SRC_msg[16*i +: 16];
            end
        end
    end

    assign w_any     = SW_req | w_src_any;
    assign w_win_msg = SW_req ? SW_msg : w_src_msg;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full);

    assign INT_valid = !w_empty && !IAQ && !IA_zero && !r_fire;
    assign INT_msg   = r_mem[r_rd_ptr];

    // IA_zero drains one message per cycle without offering it to the core.
    assign w_pop    = !w_empty && !IAQ && !r_fire && (IA_zero || INT_take);
    assign w_enq    = w_any && !r_fire && (!w_full || w_pop);
    assign w_ovf    = w_any && !r_fire && w_full && !w_pop;
    assign w_accept = (w_enq || w_ovf) && RESET_N;

    assign SW_ack  = w_accept && SW_req;
    assign SRC_ack = (w_accept && !SW_req) ? w_src_oh : '0;

    assign COUNT      = r_count;
    assign CATCH_FIRE = r_fire;

    always_ff @(negedge CORE_CLK) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_win_msg;
        end
    end

    always_ff @(negedge CORE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fire   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_ovf) begin
                r_fire <= 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcpu_int_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dcpu_int_queue
// Description : Directed bench with a message scoreboard for dcpu_int_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcpu_int_queue;

    localparam int DEPTH = 256;
    localparam int N_SRC = 4;

    logic                 CORE_CLK;
    logic                 RESET_N;
    logic [N_SRC-1:0]     SRC_req;
    logic [16*N_SRC-1:0]  SRC_msg;
    logic [N_SRC-1:0]     SRC_ack;
    logic                 SW_req;
    logic [15:0]          SW_msg;
    logic                 SW_ack;
    logic                 IAQ;
    logic                 IA_zero;
    logic                 INT_valid;
    logic [15:0]          INT_msg;
    logic                 INT_take;
    logic [8:0]           COUNT;
    logic                 CATCH_FIRE;

    int          n_checks;
    int          n_err;
    logic [15:0] sb[$];

    dcpu_int_queue #(.DEPTH(DEPTH), .N_SRC(N_SRC)) dut (
        .CORE_CLK   (CORE_CLK),
        .RESET_N    (RESET_N),
        .SRC_req    (SRC_req),
        .SRC_msg    (SRC_msg),
        .SRC_ack    (SRC_ack),
        .SW_req     (SW_req),
        .SW_msg     (SW_msg),
        .SW_ack     (SW_ack),
        .IAQ        (IAQ),
        .IA_zero    (IA_zero),
        .INT_valid  (INT_valid),
        .INT_msg    (INT_msg),
        .INT_take   (INT_take),
        .COUNT      (COUNT),
        .CATCH_FIRE (CATCH_FIRE)
    );

    initial CORE_CLK = 1'b1;
    always #5 CORE_CLK = ~CORE_CLK;

    // Inputs change 1 ns after the falling edge; checks run 2 ns later.
    task automatic tick();
        @(negedge CORE_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic deliver(input string tag);
        logic [15:0] e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s observed=output expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(INT_valid), 32'd1);
            check({tag, "_msg"}, 32'(INT_msg), 32'(e));
        end
        INT_take = 1'b1;
        tick();
        INT_take = 1'b0;
        #2;
    endtask

    task automatic sw_push(input logic [15:0] m);
        SW_req = 1'b1;
        SW_msg = m;
        sb.push_back(m);
        tick();
        SW_req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        RESET_N  = 1'b0;
        SRC_req  = '0;
        SRC_msg  = '0;
        SW_req   = 1'b1;
        SW_msg   = 16'h0BAD;
        IAQ      = 1'b0;
        IA_zero  = 1'b0;
        INT_take = 1'b0;
        #3;
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_valid", 32'(INT_valid), 32'd0);
        check("rst_fire", 32'(CATCH_FIRE), 32'd0);
        check("rst_swack", 32'(SW_ack), 32'd0);
        SW_req = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();

        // Single source request and delivery.
        SRC_req = 4'b0100;
        SRC_msg[32 +: 16] = 16'h1234;
        sb.push_back(16'h1234);
        #2;
        check("t1_ack", 32'(SRC_ack), 32'h4);
        tick();
        SRC_req = '0;
        #2;
        check("t1_ack_low", 32'(SRC_ack), 32'h0);
        check("t1_count", 32'(COUNT), 32'd1);
        deliver("t1_take");
        check("t1_count0", 32'(COUNT), 32'd0);
        check("t1_valid0", 32'(INT_valid), 32'd0);

        // Priority: SW, then src0, then src3, held while IAQ=1.
        IAQ = 1'b1;
        SW_req = 1'b1;
        SW_msg = 16'hAAAA;
        SRC_req = 4'b1001;
        SRC_msg[0 +: 16]  = 16'h0001;
        SRC_msg[48 +: 16] = 16'h0003;
        #2;
        check("t2_swack", 32'(SW_ack), 32'd1);
        check("t2_srcack_sw", 32'(SRC_ack), 32'h0);
        sb.push_back(16'hAAAA);
        tick();
        SW_req = 1'b0;
        #2;
        check("t2_srcack0", 32'(SRC_ack), 32'h1);
        sb.push_back(16'h0001);
        tick();
        SRC_req = 4'b1000;
        #2;
        check("t2_srcack3", 32'(SRC_ack), 32'h8);
        sb.push_back(16'h0003);
        tick();
        SRC_req = '0;
        #2;
        check("t2_count", 32'(COUNT), 32'd3);
        check("t2_blocked", 32'(INT_valid), 32'd0);
        IAQ = 1'b0;
        #1;
        check("t2_iaq_drop", 32'(INT_valid), 32'd1);
        for (int i = 0; i < 3; i++) deliver("t2_drain");

        // Fill to capacity, then simultaneous take + enqueue at full.
        IAQ = 1'b1;
        for (int i = 0; i < DEPTH; i++) sw_push(16'(i * 3 + 7));
        #2;
        check("t3_full", 32'(COUNT), 32'd256);
        check("t3_nofire", 32'(CATCH_FIRE), 32'd0);
        IAQ = 1'b0;
        SRC_req = 4'b0010;
        SRC_msg[16 +: 16] = 16'hBEEF;
        #1;
        check("t4_ack", 32'(SRC_ack), 32'h2);
        deliver("t4_take");
        SRC_req = '0;
        sb.push_back(16'hBEEF);
        check("t4_count", 32'(COUNT), 32'd256);
        check("t4_nofire", 32'(CATCH_FIRE), 32'd0);
        for (int i = 0; i < DEPTH; i++) deliver("t4_drain");
        check("t4_empty", 32'(COUNT), 32'd0);

        // Overflow freezes the queue.
        IAQ = 1'b1;
        for (int i = 0; i < DEPTH; i++) sw_push(16'(i ^ 16'h5555));
        SRC_req = 4'b0001;
        SRC_msg[0 +: 16] = 16'hDEAD;
        #2;
        check("t3_ovf_ack", 32'(SRC_ack), 32'h1);
        tick();
        SRC_req = '0;
        #2;
        check("t3_fire", 32'(CATCH_FIRE), 32'd1);
        check("t3_count_hold", 32'(COUNT), 32'd256);
        SW_req = 1'b1;
        SRC_req = 4'b1111;
        #1;
        check("t3_frozen_sw", 32'(SW_ack), 32'd0);
        check("t3_frozen_src", 32'(SRC_ack), 32'h0);
        IAQ = 1'b0;
        INT_take = 1'b1;
        #1;
        check("t3_frozen_valid", 32'(INT_valid), 32'd0);
        tick();
        SW_req = 1'b0;
        SRC_req = '0;
        INT_take = 1'b0;
        #2;
        check("t3_frozen_count", 32'(COUNT), 32'd256);
        RESET_N = 1'b0;
        #1;
        check("t3_rst_fire", 32'(CATCH_FIRE), 32'd0);
        sb.delete();
        tick();
        RESET_N = 1'b1;

        // IA_zero discards one message per cycle without offering it.
        IAQ = 1'b1;
        for (int i = 0; i < 5; i++) sw_push(16'(16'h0100 + i));
        sb.delete();
        IA_zero = 1'b1;
        IAQ = 1'b0;
        INT_take = 1'b1;
        for (int i = 5; i > 0; i--) begin
            #2;
            check("t5_count", 32'(COUNT), 32'(i));
            check("t5_novalid", 32'(INT_valid), 32'd0);
            tick();
        end
        #2;
        check("t5_empty", 32'(COUNT), 32'd0);
        INT_take = 1'b0;
        IA_zero = 1'b0;

        // Asynchronous reset mid-drain.
        IAQ = 1'b1;
        for (int i = 0; i < 9; i++) sw_push(16'(16'h0200 + i));
        IAQ = 1'b0;
        #2;
        deliver("t6_pre");
        deliver("t6_pre");
        check("t6_count7", 32'(COUNT), 32'd7);
        RESET_N = 1'b0;
        #1;
        check("t6_rst_count", 32'(COUNT), 32'd0);
        check("t6_rst_valid", 32'(INT_valid), 32'd0);
        check("t6_rst_fire", 32'(CATCH_FIRE), 32'd0);
        sb.delete();
        tick();
        RESET_N = 1'b1;
        SRC_req = 4'b1000;
        SRC_msg[48 +: 16] = 16'h5A5A;
        sb.push_back(16'h5A5A);
        #2;
        check("t6_ack", 32'(SRC_ack), 32'h8);
        tick();
        SRC_req = '0;
        #2;
        check("t6_count1", 32'(COUNT), 32'd1);
        deliver("t6_post");
        check("t6_final", 32'(COUNT), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
